// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: select codes,
// legal XLEN values and the output buffer state encoding.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_Z    = 3'b101,
        IMM_SH   = 3'b110,
        IMM_RSVD = 3'b111
    } imm_sel_e;

    localparam int XLEN_32 = 32;
    localparam int XLEN_64 = 64;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: builds the 32-bit form of each immediate
// type, then sign- or zero-extends it to XLEN. Reserved select flags err_o.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_32
) (
    input  logic [31:0]     instr_i,
    input  logic [2:0]      sel_i,
    output logic [XLEN-1:0] imm_o,
    output logic            err_o
);

    logic [31:0] imm32;
    logic        sext;

    always_comb begin
        imm32 = '0;
        sext  = 1'b0;
        err_o = 1'b0;
        case (imm_sel_e'(sel_i))
            IMM_I: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
                sext  = 1'b1;
            end
            IMM_S: begin
                imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                sext  = 1'b1;
            end
            IMM_B: begin
                imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
                sext  = 1'b1;
            end
            IMM_J: begin
                imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
                sext  = 1'b1;
            end
            IMM_U: begin
                imm32 = {instr_i[31:12], 12'b0};
                sext  = 1'b1;
            end
            IMM_Z: begin
                imm32 = {27'b0, instr_i[19:15]};
            end
            IMM_SH: begin
                // RV64 shifts use a 6-bit shamt; bit 25 is part of funct7 on RV32
                if (XLEN == XLEN_64) begin
                    imm32 = {26'b0, instr_i[25:20]};
                end else begin
                    imm32 = {27'b0, instr_i[24:20]};
                end
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

    assign imm_o = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator: decode on accept, result one cycle later.
// Two-entry skid buffer (main drives out_*, skid holds overflow); in_ready decodes state only.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } beat_t;

    buf_state_e      state_q, state_d;
    beat_t           main_q, main_d;
    beat_t           skid_q, skid_d;
    beat_t           new_beat;
    logic [XLEN-1:0] dec_imm;
    logic            dec_err;
    logic            accept;
    logic            pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i (in_instr),
        .sel_i   (in_sel),
        .imm_o   (dec_imm),
        .err_o   (dec_err)
    );

    assign new_beat = '{imm: dec_imm, tag: in_tag, err: dec_err};

    assign in_ready  = (state_q != BUF_TWO);
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Registers keep stale data; out_valid low makes it invisible
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_d  = new_beat;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        main_d = new_beat;
                    end else if (accept) begin
                        skid_d  = new_beat;
                        state_d = BUF_TWO;
                    end else if (pop) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BUF_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    assign out_imm = main_q.imm;
    assign out_tag = main_q.tag;
    assign out_err = main_q.err;

endmodule
